fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter N, default 1024, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning byte address fetched first after reset.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port imem_re, output, 1, read enable to the instruction ROM.
REQ-006 SHALL have port imem_a, output, $clog2(N), word address to the ROM.
REQ-007 SHALL have port imem_rd, input, 32, ROM read data, valid the cycle after imem_re.
REQ-008 SHALL have port redirect, input, 1, branch/jump/trap redirect request.
REQ-009 SHALL have port redirect_pc, input, 32, redirect target byte address.
REQ-010 SHALL have port if_valid, output, 1, an instruction is presented to decode.
REQ-011 SHALL have port if_ready, input, 1, decode accepts the instruction.
REQ-012 SHALL have ports if_instr (output, 32, instruction word) and if_pc (output, 32, its byte address).

Function
REQ-013 SHALL hold a 32-bit pc register; imem_a = pc[$clog2(N)+1:2]; pc[1:0] is always 0.
REQ-014 SHALL issue a read (imem_re=1) when rst_n=1, redirect=0, and (buffer occupancy + in-flight count) < 2 or a pop occurs this cycle; each issue advances pc by 4 (32-bit wrap) and sets in-flight with its pc.
REQ-015 SHALL treat ROM latency as exactly one cycle: an in-flight request's imem_rd is pushed, with its pc, into a 2-entry FIFO at the end of the following cycle.
REQ-016 SHALL drive if_valid = (occupancy != 0) && !redirect; if_instr/if_pc from the FIFO head; pop on if_valid && if_ready.
REQ-017 SHALL support simultaneous push and pop without loss; occupancy never exceeds 2 and no response is ever dropped except by redirect.
REQ-018 SHALL sustain one instruction per cycle when if_ready is held high.
REQ-019 SHALL hold if_instr/if_pc stable while if_valid=1 and if_ready=0.
REQ-020 SHALL on redirect: flush the FIFO, cancel the in-flight response (no push), suppress issue, load pc <= {redirect_pc[31:2],2'b00}.
REQ-021 SHALL present the redirect target on if_valid 3 cycles after the redirect cycle (issue R+1, data R+2, valid R+3).
REQ-022 SHALL let address index wrap modulo N (pc beyond ROM aliases); no error signalled.

Reset
REQ-023 SHALL on rst_n=0 asynchronously clear FIFO and in-flight, load pc <= RESET_PC, and force imem_re=0, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=RESET_PC.
REQ-024 SHALL issue RESET_PC in the first cycle after rst_n deasserts, if_valid=1 two cycles later.
REQ-025 SHALL on reset mid-operation discard all buffered and in-flight instructions.

Structure
REQ-026 SHALL take XLEN=32, NOP encoding 32'h0000_0013 and default RESET_PC from shared package riscv_pkg.
REQ-027 SHALL implement the 2-entry instruction+pc queue as sub-module fetch_buf (push, pop, flush, count).

Verification
REQ-028 Reset release with if_ready=1, ROM[k]=k -> imem_a 0,1,2,... every cycle; if_pc 0,4,8 from cycle 2, one per cycle.
REQ-029 if_ready=0 for 5 cycles from steady state -> occupancy reaches 2, imem_re drops, if_instr held; resume -> no skipped or duplicated pc.
REQ-030 redirect=1, redirect_pc=32'h0000_0103 -> next imem_a=64, if_valid low R..R+2, if_pc=32'h100 at R+3, stale words never appear.
REQ-031 redirect while FIFO full and if_ready=0 -> FIFO empty next cycle, target delivered at R+3.
REQ-032 pc=4*(N-1) with N=1024 -> next imem_a=0, if_pc=32'h1000, no stall.
REQ-033 rst_n asserted mid-cycle during streaming -> outputs immediately reset values; restart from RESET_PC per REQ-024.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the payload carried through the fetch queue.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  // Force a byte address onto a 32-bit word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry instruction+pc queue between the ROM response and decode.
// Entry "head" is always the oldest word; push and pop may coincide.
module fetch_buf
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  fetch_pkt_t din,
  input  logic       pop,
  input  logic       flush,
  output fetch_pkt_t head,
  output logic [1:0] count
);

  localparam fetch_pkt_t RESET_PKT = '{instr: NOP_INSTR, pc: RESET_PC};

  fetch_pkt_t entry1;
  logic       do_pop;
  logic       do_push;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  // Shift-style storage: a pop moves entry1 into head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head   <= RESET_PKT;
      entry1 <= RESET_PKT;
      count  <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b11: begin
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head   <= entry1;
            entry1 <= din;
          end
        end
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               entry1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= entry1;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word reads to a 1-cycle ROM, buffers responses
// in a 2-entry queue and hands them to decode with a valid/ready handshake.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     N        = 1024,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_re,
  output logic [$clog2(N)-1:0] imem_a,
  input  logic [XLEN-1:0]      imem_rd,
  input  logic                 redirect,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 if_valid,
  input  logic                 if_ready,
  output logic [XLEN-1:0]      if_instr,
  output logic [XLEN-1:0]      if_pc
);

  localparam int unsigned AW = $clog2(N);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [1:0]      count;
  logic [1:0]      pending;
  logic            pop;
  logic            push;
  fetch_pkt_t      head;
  fetch_pkt_t      resp;

  // Buffered plus outstanding words never exceed the queue depth.
  assign pending  = count + 2'(inflight);
  assign if_valid = (count != 2'd0) && !redirect;
  assign pop      = if_valid && if_ready;
  assign imem_re  = rst_n && !redirect && ((pending < 2'd2) || pop);
  assign imem_a   = pc[AW+1:2];

  // A redirect cancels the response that is landing this cycle.
  assign push = inflight && !redirect;
  assign resp = '{instr: imem_rd, pc: inflight_pc};

  assign if_instr = head.instr;
  assign if_pc    = head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= align_word(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (redirect) begin
      pc       <= align_word(redirect_pc);
      inflight <= 1'b0;
    end else begin
      inflight <= imem_re;
      if (imem_re) begin
        pc          <= pc + XLEN'(4);
        inflight_pc <= pc;
      end
    end
  end

  fetch_buf #(
    .RESET_PC (RESET_PC)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (resp),
    .pop   (pop),
    .flush (redirect),
    .head  (head),
    .count (count)
  );

endmodule
